// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped 8N1 UART with TX and RX FIFOs for the FemtoRV IO page.
//
// Ports:
//   clk, resetn        system clock; asynchronous active-low reset
//   rstrb, wstrb       CPU read / write strobes
//   sel_dat            data register: write pushes a TX byte, read gives {rx_valid, rx_head}
//   sel_cntl           status register; writing 1 to bits 3/4/5 clears rx_ovr/frame_err/tx_ovf
//   sel_div            baud divisor in clk cycles per bit (clamped to MIN_DIV)
//   wdata, rdata       write data; combinational read data (0 when nothing is selected)
//   RXD, TXD           serial input (asynchronous) and output
//   brk                one-cycle pulse whenever 0x03 is received with a valid stop bit
module uart_fifo #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned DEFAULT_DIV = 104,
   parameter int unsigned MIN_DIV     = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rstrb,
   input  logic        wstrb,
   input  logic        sel_dat,
   input  logic        sel_cntl,
   input  logic        sel_div,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        RXD,
   output logic        TXD,
   output logic        brk
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_t;

   // Bus decode
   logic w_dat_wr, w_dat_rd, w_ctl_wr, w_div_wr;
   assign w_dat_wr = wstrb & sel_dat;
   assign w_dat_rd = rstrb & sel_dat;
   assign w_ctl_wr = wstrb & sel_cntl;
   assign w_div_wr = wstrb & sel_div;

   // Divisor register
   logic [15:0] r_div;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_div <= 16'(DEFAULT_DIV);
      end else if (w_div_wr) begin
         r_div <= (wdata[15:0] < 16'(MIN_DIV)) ? 16'(MIN_DIV) : wdata[15:0];
      end
   end

   // TX FIFO
   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp;
   logic [CW-1:0] r_tx_cnt;
   logic          w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
   logic [7:0]    w_tx_head;

   assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
   assign w_tx_empty = (r_tx_cnt == '0);
   // A full FIFO refuses the write even if the engine pops in the same cycle.
   assign w_tx_push  = w_dat_wr & ~w_tx_full;
   assign w_tx_head  = r_tx_mem[r_tx_rp];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
   end

   // RX FIFO
   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_wp, r_rx_rp;
   logic [CW-1:0] r_rx_cnt;
   logic          w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_valid;
   logic [7:0]    w_rx_head;
   logic          r_rx_push;
   logic [7:0]    r_rx_byte;

   assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_valid = ~w_rx_empty;
   assign w_rx_pop   = w_dat_rd & ~w_rx_empty;
   // At full, a simultaneous CPU pop frees the slot the new byte lands in.
   assign w_rx_push  = r_rx_push & (~w_rx_full | w_rx_pop);
   assign w_rx_head  = r_rx_mem[r_rx_rp];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_byte;
   end

   // TX engine
   tx_state_t   r_tx_state, w_tx_state_d;
   logic [15:0] r_tx_bcnt, w_tx_bcnt_d, r_tx_div, w_tx_div_d;
   logic [2:0]  r_tx_bit, w_tx_bit_d;
   logic [7:0]  r_tx_shift, w_tx_shift_d;
   logic        w_tx_bit_end, w_tx_idle;

   assign w_tx_bit_end = (r_tx_bcnt == r_tx_div - 16'd1);
   assign w_tx_idle    = w_tx_empty & (r_tx_state == TxIdle);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tx_state <= TxIdle;
         r_tx_bcnt  <= '0;
         r_tx_div   <= 16'(DEFAULT_DIV);
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
      end else begin
         r_tx_state <= w_tx_state_d;
         r_tx_bcnt  <= w_tx_bcnt_d;
         r_tx_div   <= w_tx_div_d;
         r_tx_bit   <= w_tx_bit_d;
         r_tx_shift <= w_tx_shift_d;
      end
   end

   always_comb begin
      w_tx_state_d = r_tx_state;
      w_tx_bcnt_d  = r_tx_bcnt;
      w_tx_div_d   = r_tx_div;
      w_tx_bit_d   = r_tx_bit;
      w_tx_shift_d = r_tx_shift;
      w_tx_pop     = 1'b0;
      TXD          = 1'b1;
      case (r_tx_state)
         TxIdle: begin
            if (!w_tx_empty) begin
               w_tx_pop     = 1'b1;
               w_tx_shift_d = w_tx_head;
               w_tx_div_d   = r_div;
               w_tx_bcnt_d  = '0;
               w_tx_state_d = TxStart;
            end
         end
         TxStart: begin
            TXD = 1'b0;
            if (w_tx_bit_end) begin
               w_tx_bcnt_d  = '0;
               w_tx_bit_d   = '0;
               w_tx_state_d = TxData;
            end else begin
               w_tx_bcnt_d = r_tx_bcnt + 16'd1;
            end
         end
         TxData: begin
            TXD = r_tx_shift[0];
            if (w_tx_bit_end) begin
               w_tx_bcnt_d  = '0;
               w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
               w_tx_bit_d   = r_tx_bit + 3'd1;
               if (r_tx_bit == 3'd7) w_tx_state_d = TxStop;
            end else begin
               w_tx_bcnt_d = r_tx_bcnt + 16'd1;
            end
         end
         TxStop: begin
            if (w_tx_bit_end) begin
               w_tx_bcnt_d = '0;
               // Chain straight into the next frame so back-to-back bytes have no gap.
               if (!w_tx_empty) begin
                  w_tx_pop     = 1'b1;
                  w_tx_shift_d = w_tx_head;
                  w_tx_div_d   = r_div;
                  w_tx_state_d = TxStart;
               end else begin
                  w_tx_state_d = TxIdle;
               end
            end else begin
               w_tx_bcnt_d = r_tx_bcnt + 16'd1;
            end
         end
         default: w_tx_state_d = TxIdle;
      endcase
   end

   // RX synchroniser. Resetting to 0 means a line already low at reset release
   // is not mistaken for a start bit; a real high must be seen first.
   logic r_rxd_meta, r_rxd_sync, r_rxd_prev;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rxd_meta <= 1'b0;
         r_rxd_sync <= 1'b0;
         r_rxd_prev <= 1'b0;
      end else begin
         r_rxd_meta <= RXD;
         r_rxd_sync <= r_rxd_meta;
         r_rxd_prev <= r_rxd_sync;
      end
   end

   // RX engine
   rx_state_t   r_rx_state, w_rx_state_d;
   logic [15:0] r_rx_bcnt, w_rx_bcnt_d, r_rx_div, w_rx_div_d;
   logic [2:0]  r_rx_bit, w_rx_bit_d;
   logic [7:0]  r_rx_shift, w_rx_shift_d;
   logic        w_rx_push_d, w_rx_ferr, w_rx_bit_end, w_rx_half_end;
   logic        r_brk;

   assign w_rx_bit_end  = (r_rx_bcnt == r_rx_div - 16'd1);
   assign w_rx_half_end = (r_rx_bcnt == (r_rx_div >> 1) - 16'd1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_state <= RxIdle;
         r_rx_bcnt  <= '0;
         r_rx_div   <= 16'(DEFAULT_DIV);
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_push  <= 1'b0;
         r_rx_byte  <= '0;
         r_brk      <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_d;
         r_rx_bcnt  <= w_rx_bcnt_d;
         r_rx_div   <= w_rx_div_d;
         r_rx_bit   <= w_rx_bit_d;
         r_rx_shift <= w_rx_shift_d;
         r_rx_push  <= w_rx_push_d;
         if (w_rx_push_d) r_rx_byte <= r_rx_shift;
         // Break fires on every good 0x03, whether or not the FIFO accepted it.
         r_brk <= r_rx_push & (r_rx_byte == 8'h03);
      end
   end

   always_comb begin
      w_rx_state_d = r_rx_state;
      w_rx_bcnt_d  = r_rx_bcnt;
      w_rx_div_d   = r_rx_div;
      w_rx_bit_d   = r_rx_bit;
      w_rx_shift_d = r_rx_shift;
      w_rx_push_d  = 1'b0;
      w_rx_ferr    = 1'b0;
      case (r_rx_state)
         RxIdle: begin
            if (!r_rxd_sync && r_rxd_prev) begin
               w_rx_bcnt_d  = '0;
               w_rx_div_d   = r_div;
               w_rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (w_rx_half_end) begin
               w_rx_bcnt_d  = '0;
               w_rx_bit_d   = '0;
               w_rx_state_d = r_rxd_sync ? RxIdle : RxData;
            end else begin
               w_rx_bcnt_d = r_rx_bcnt + 16'd1;
            end
         end
         RxData: begin
            if (w_rx_bit_end) begin
               w_rx_bcnt_d  = '0;
               w_rx_shift_d = {r_rxd_sync, r_rx_shift[7:1]};
               w_rx_bit_d   = r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7) w_rx_state_d = RxStop;
            end else begin
               w_rx_bcnt_d = r_rx_bcnt + 16'd1;
            end
         end
         RxStop: begin
            if (w_rx_bit_end) begin
               w_rx_bcnt_d = '0;
               if (r_rxd_sync) begin
                  w_rx_push_d  = 1'b1;
                  w_rx_state_d = RxIdle;
               end else begin
                  w_rx_ferr    = 1'b1;
                  w_rx_state_d = RxWaitHigh;
               end
            end else begin
               w_rx_bcnt_d = r_rx_bcnt + 16'd1;
            end
         end
         RxWaitHigh: begin
            if (r_rxd_sync) w_rx_state_d = RxIdle;
         end
         default: w_rx_state_d = RxIdle;
      endcase
   end

   assign brk = r_brk;

   // Sticky flags: a set in the same cycle as a clear wins.
   logic r_rx_ovr, r_ferr, r_tx_ovf;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_ovr <= 1'b0;
         r_ferr   <= 1'b0;
         r_tx_ovf <= 1'b0;
      end else begin
         r_rx_ovr <= (r_rx_push & w_rx_full & ~w_rx_pop) | (r_rx_ovr & ~(w_ctl_wr & wdata[3]));
         r_ferr   <= w_rx_ferr | (r_ferr & ~(w_ctl_wr & wdata[4]));
         r_tx_ovf <= (w_dat_wr & w_tx_full) | (r_tx_ovf & ~(w_ctl_wr & wdata[5]));
      end
   end

   // Read mux
   logic [31:0] w_status;
   assign w_status = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), 2'b00,
                      r_tx_ovf, r_ferr, r_rx_ovr, w_tx_idle, w_tx_full, w_rx_valid};

   always_comb begin
      rdata = 32'h0;
      if (sel_dat)       rdata = {23'h0, w_rx_valid, w_rx_head};
      else if (sel_cntl) rdata = w_status;
      else if (sel_div)  rdata = {16'h0, r_div};
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo (FIFO_DEPTH=4): reset, TX framing, RX loopback,
// overflow flags, frame errors, glitch rejection and break detection.
module tb_uart_fifo;

   localparam logic [2:0] SEL_DAT = 3'b100;
   localparam logic [2:0] SEL_CTL = 3'b010;
   localparam logic [2:0] SEL_DIV = 3'b001;

   logic        clk, resetn, rstrb, wstrb, sel_dat, sel_cntl, sel_div;
   logic [31:0] wdata, rdata;
   logic        rxd, rxd_drv, loop_en, txd, brk;
   int          n_vec, n_err, brk_total;

   assign rxd = loop_en ? txd : rxd_drv;

   uart_fifo #(.FIFO_DEPTH(4), .DEFAULT_DIV(104), .MIN_DIV(4)) dut (
      .clk(clk), .resetn(resetn), .rstrb(rstrb), .wstrb(wstrb),
      .sel_dat(sel_dat), .sel_cntl(sel_cntl), .sel_div(sel_div),
      .wdata(wdata), .rdata(rdata), .RXD(rxd), .TXD(txd), .brk(brk)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (brk === 1'b1) brk_total++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic bus_wr(input logic [2:0] sel, input logic [31:0] d);
      @(negedge clk);
      {sel_dat, sel_cntl, sel_div} = sel;
      wstrb = 1'b1;
      wdata = d;
      @(negedge clk);
      wstrb = 1'b0;
      {sel_dat, sel_cntl, sel_div} = 3'b000;
   endtask

   task automatic bus_rd(input logic [2:0] sel, input logic pop, output logic [31:0] d);
      @(negedge clk);
      {sel_dat, sel_cntl, sel_div} = sel;
      rstrb = pop;
      #1 d = rdata;
      @(negedge clk);
      rstrb = 1'b0;
      {sel_dat, sel_cntl, sel_div} = 3'b000;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int len);
      @(negedge clk);
      rxd_drv = 1'b0;
      repeat (len) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = b[i];
         repeat (len) @(negedge clk);
      end
      rxd_drv = stop;
      repeat (len) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (2 * len) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #1 resetn = 1'b0;
      #1;
      n_vec++;
      if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd got %b want 1", txd); end
      n_vec++;
      if (brk !== 1'b0) begin n_err++; $display("FAIL reset_brk got %b want 0", brk); end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h4) begin n_err++; $display("FAIL reset_status got %h want 00000004", d); end
      bus_rd(SEL_DIV, 1'b0, d);
      n_vec++;
      if (d !== 32'd104) begin n_err++; $display("FAIL reset_div got %0d want 104", d); end
      // Start a frame, then pull reset in the middle of the start bit.
      bus_wr(SEL_DAT, 32'hFF);
      repeat (20) @(negedge clk);
      n_vec++;
      if (txd !== 1'b0) begin n_err++; $display("FAIL midframe_start got %b want 0", txd); end
      #3 resetn = 1'b0;
      #1;
      n_vec++;
      if (txd !== 1'b1) begin n_err++; $display("FAIL async_reset_txd got %b want 1", txd); end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h4) begin n_err++; $display("FAIL rereset_status got %h want 00000004", d); end
   endtask

   task automatic test_div();
      logic [31:0] d;
      bus_wr(SEL_DIV, 32'h2);
      bus_rd(SEL_DIV, 1'b0, d);
      n_vec++;
      if (d !== 32'd4) begin n_err++; $display("FAIL div_clamp got %0d want 4", d); end
      bus_wr(SEL_DIV, 32'h8);
      bus_rd(SEL_DIV, 1'b0, d);
      n_vec++;
      if (d !== 32'd8) begin n_err++; $display("FAIL div_write got %0d want 8", d); end
   endtask

   task automatic test_tx();
      logic [31:0] d;
      logic [19:0] got, exp;
      logic        found;
      exp   = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
      got   = '0;
      found = 1'b0;
      fork
         begin
            bus_wr(SEL_DAT, 32'h55);
            bus_wr(SEL_DAT, 32'hA3);
         end
         begin
            for (int i = 0; i < 400 && !found; i++) begin
               @(negedge clk);
               if (txd === 1'b0) found = 1'b1;
            end
            if (found) begin
               repeat (4) @(negedge clk);
               got[0] = txd;
               for (int k = 1; k < 20; k++) begin
                  repeat (8) @(negedge clk);
                  got[k] = txd;
               end
            end
         end
      join
      n_vec++;
      if (found !== 1'b1) begin n_err++; $display("FAIL tx_start_seen got %b want 1", found); end
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL tx_serial got %b want %b", got, exp); end
      repeat (6) @(negedge clk);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h4) begin n_err++; $display("FAIL tx_idle_status got %h want 00000004", d); end
   endtask

   task automatic test_loopback();
      logic [31:0] d;
      loop_en = 1'b1;
      bus_wr(SEL_DAT, 32'h41);
      bus_wr(SEL_DAT, 32'h42);
      bus_wr(SEL_DAT, 32'h43);
      repeat (300) @(negedge clk);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h0305) begin n_err++; $display("FAIL loop_status got %h want 00000305", d); end
      bus_rd(SEL_DAT, 1'b1, d);
      n_vec++;
      if (d !== 32'h141) begin n_err++; $display("FAIL loop_rd0 got %h want 00000141", d); end
      bus_rd(SEL_DAT, 1'b1, d);
      n_vec++;
      if (d !== 32'h142) begin n_err++; $display("FAIL loop_rd1 got %h want 00000142", d); end
      bus_rd(SEL_DAT, 1'b1, d);
      n_vec++;
      if (d !== 32'h143) begin n_err++; $display("FAIL loop_rd2 got %h want 00000143", d); end
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h4) begin n_err++; $display("FAIL loop_drained got %h want 00000004", d); end
      bus_rd(SEL_DAT, 1'b1, d);
      n_vec++;
      if (d[31:8] !== 24'h0) begin n_err++; $display("FAIL empty_read got %h want 000000xx", d); end
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h4) begin n_err++; $display("FAIL empty_pop_status got %h want 00000004", d); end
      loop_en = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      for (int i = 0; i < 6; i++) bus_wr(SEL_DAT, 32'h60 + i);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h0004_0022) begin
         n_err++; $display("FAIL tx_ovf_status got %h want 00040022", d);
      end
      repeat (450) @(negedge clk);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h24) begin n_err++; $display("FAIL tx_drain_status got %h want 00000024", d); end
      loop_en = 1'b1;
      for (int i = 0; i < 5; i++) bus_wr(SEL_DAT, 32'h10 + i);
      repeat (480) @(negedge clk);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h042D) begin n_err++; $display("FAIL rx_ovr_status got %h want 0000042d", d); end
      loop_en = 1'b0;
      bus_wr(SEL_CTL, 32'h38);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h0405) begin n_err++; $display("FAIL flag_clear got %h want 00000405", d); end
      for (int i = 0; i < 4; i++) begin
         bus_rd(SEL_DAT, 1'b1, d);
         n_vec++;
         if (d !== 32'h110 + i) begin
            n_err++; $display("FAIL ovr_keep%0d got %h want %h", i, d, 32'h110 + i);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] d;
      send_rx(8'h33, 1'b0, 8);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h14) begin n_err++; $display("FAIL frame_err got %h want 00000014", d); end
      bus_wr(SEL_CTL, 32'h10);
      send_rx(8'h5A, 1'b1, 8);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h0105) begin n_err++; $display("FAIL after_ferr got %h want 00000105", d); end
      bus_rd(SEL_DAT, 1'b1, d);
      n_vec++;
      if (d !== 32'h15A) begin n_err++; $display("FAIL after_ferr_data got %h want 0000015a", d); end
      bus_wr(SEL_DIV, 32'd104);
      @(negedge clk);
      rxd_drv = 1'b0;
      repeat (20) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (300) @(negedge clk);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h4) begin n_err++; $display("FAIL glitch got %h want 00000004", d); end
      bus_wr(SEL_DIV, 32'd8);
   endtask

   task automatic test_break();
      logic [31:0] d;
      int          b0;
      for (int i = 0; i < 4; i++) send_rx(8'h20 + 8'(i), 1'b1, 8);
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h0405) begin n_err++; $display("FAIL brk_prefill got %h want 00000405", d); end
      b0 = brk_total;
      send_rx(8'h03, 1'b1, 8);
      n_vec++;
      if (brk_total - b0 !== 1) begin
         n_err++; $display("FAIL brk_pulse got %0d cycles want 1", brk_total - b0);
      end
      bus_rd(SEL_CTL, 1'b0, d);
      n_vec++;
      if (d !== 32'h040D) begin n_err++; $display("FAIL brk_ovr got %h want 0000040d", d); end
   endtask

   initial begin
      n_vec = 0; n_err = 0; brk_total = 0;
      resetn = 1'b1; rstrb = 1'b0; wstrb = 1'b0;
      sel_dat = 1'b0; sel_cntl = 1'b0; sel_div = 1'b0;
      wdata = '0; rxd_drv = 1'b1; loop_en = 1'b0;
      test_reset();
      test_div();
      test_tx();
      test_loopback();
      test_overflow();
      test_errors();
      test_break();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
